seq_top: RTL and testbench
==========================

Name: seq_top

Overview:
- Small sequenced datapath generated as a three-step sequential program.
- After reset it runs exactly one pass of three steps. Each step updates a subset of four 8-bit output registers.
- It then parks in a DONE state with the outputs held.
- Serves as a top-level demonstration and regression block for sequential-state-register codegen.

Parameters:
- A_INIT, 3, value loaded into a by step 0
- B_INIT, 16, value loaded into b by step 0
- MUL, 3, multiplier applied to a and b in step 1

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- a  output  8  register output A
- b  output  8  register output B
- c  output  8  register output C (sum result)
- d  output  8  register output D (difference result)

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- One-hot state registers: S0, S1, S2, DONE (four flops, exactly one set at any time).
- Outputs a, b, c and d are driven directly from registers, with no combinational path from inputs.
- Reset (rst=1 at a rising edge):
  - a, b, c, d all become 0.
  - State becomes S0.
  - Reset has priority over every step action.
- Step S0 (first edge with rst=0): a <= A_INIT (3); b <= B_INIT (16); c and d unchanged (0); next state S1.
- Step S1 (second edge): a <= a*MUL, truncated to 8 bits (9); b <= b*MUL, truncated to 8 bits (48); next state S2.
- Step S2 (third edge): c <= a+b mod 256 (57); d <= b-a mod 256 (39, two's-complement wrap if negative); a and b hold; next state DONE.
- DONE: all registers hold indefinitely. No further state change until rst is asserted.
- Arithmetic width rule:
  - All arithmetic is unsigned 8-bit.
  - Overflow wraps: upper product/sum bits are discarded, and the borrow on subtraction is discarded.
- Latency:
  - a and b reach their final values after 2 non-reset edges.
  - c and d reach their final values after 3 non-reset edges.
- Reset mid-sequence:
  - rst=1 at any edge in S0, S1, S2 or DONE clears all outputs to 0 and returns to S0.
  - The sequence restarts from step S0 on the next edge with rst=0.
- Reset held for multiple cycles: the block stays in S0 with outputs 0. Steps begin only on the first edge where rst=0.
- Registers are not updated other than as listed above. In particular, a and b are never written in S2 or DONE.

Test Plan:
- Reset 1 cycle, then 3 clocks with rst=0 -> a=9, b=48, c=57, d=39; values unchanged for the following 99 cycles.
- Reset 1 cycle, then 1 clock -> a=3, b=16, c=0, d=0; after 2nd clock -> a=9, b=48, c=0, d=0.
- Hold rst=1 for 5 cycles -> a=b=c=d=0 throughout. The first rst=0 edge yields a=3, b=16.
- Run to DONE, assert rst for 1 cycle -> all outputs 0. Three further clocks -> a=9, b=48, c=57, d=39 again.
- Assert rst while in S1 (after the first step) -> outputs 0 next edge. The sequence restarts with a=3, b=16 on the following edge.
- Parameter override A_INIT=100, B_INIT=200, MUL=3 -> after 3 clocks a=44 (300 mod 256), b=88 (600 mod 256), c=132, d=44. This checks 8-bit wrap.

Source files
------------

// File: rtl/seq_top.sv
// Three-step sequenced datapath: loads a/b, scales them, then forms sum and
// difference into c/d before parking in DONE until the next reset.
module seq_top #(
  parameter int unsigned A_INIT = 3,
  parameter int unsigned B_INIT = 16,
  parameter int unsigned MUL    = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d
);

  localparam logic [7:0] A_INIT8 = A_INIT[7:0];
  localparam logic [7:0] B_INIT8 = B_INIT[7:0];
  localparam logic [7:0] MUL8    = MUL[7:0];

  // One-hot encoding: each state owns exactly one flop.
  typedef enum logic [3:0] {
    S0   = 4'b0001,
    S1   = 4'b0010,
    S2   = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] c_q, c_d;
  logic [7:0] d_q, d_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
    end
  end

  // All arithmetic stays 8 bits wide so carries and borrows drop off.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    case (state_q)
      S0: begin
        a_d     = A_INIT8;
        b_d     = B_INIT8;
        state_d = S1;
      end
      S1: begin
        a_d     = a_q * MUL8;
        b_d     = b_q * MUL8;
        state_d = S2;
      end
      S2: begin
        c_d     = a_q + b_q;
        d_d     = b_q - a_q;
        state_d = DONE;
      end
      DONE: state_d = DONE;
      default: state_d = S0;
    endcase
  end

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign d = d_q;

endmodule

// File: tb/tb_seq_top.sv
// Directed bench for seq_top: default instance plus an overridden instance
// exercising 8-bit wrap, both driven from a shared clock and reset.
module tb_seq_top;

  logic       clk;
  logic       rst;
  logic [7:0] a, b, c, d;
  logic [7:0] oa, ob, oc, od;

  int unsigned checks;
  int unsigned passed;

  seq_top dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d)
  );

  seq_top #(.A_INIT(100), .B_INIT(200), .MUL(3)) dut_ovr (
    .clk(clk), .rst(rst), .a(oa), .b(ob), .c(oc), .d(od)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic chk4(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                      input logic [7:0] ec, input logic [7:0] ed);
    chk({tag, ".a"}, {24'd0, a}, {24'd0, ea});
    chk({tag, ".b"}, {24'd0, b}, {24'd0, eb});
    chk({tag, ".c"}, {24'd0, c}, {24'd0, ec});
    chk({tag, ".d"}, {24'd0, d}, {24'd0, ed});
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst    = 1'b1;

    // Basic pass after a single reset cycle
    tick();
    chk4("reset", 8'd0, 8'd0, 8'd0, 8'd0);
    rst = 1'b0;
    tick();
    chk4("step0", 8'd3, 8'd16, 8'd0, 8'd0);
    tick();
    chk4("step1", 8'd9, 8'd48, 8'd0, 8'd0);
    tick();
    chk4("step2", 8'd9, 8'd48, 8'd57, 8'd39);
    chk("ovr.a", {24'd0, oa}, 32'd44);
    chk("ovr.b", {24'd0, ob}, 32'd88);
    chk("ovr.c", {24'd0, oc}, 32'd132);
    chk("ovr.d", {24'd0, od}, 32'd44);

    for (int i = 0; i < 99; i++) begin
      tick();
      chk("done_hold", {a, b, c, d}, {8'd9, 8'd48, 8'd57, 8'd39});
    end

    // Reset from DONE, then rerun
    rst = 1'b1;
    tick();
    chk4("rst_done", 8'd0, 8'd0, 8'd0, 8'd0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk4("rerun", 8'd9, 8'd48, 8'd57, 8'd39);

    // Reset held for five edges
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_hold", {a, b, c, d}, 32'd0);
    end
    rst = 1'b0;
    tick();
    chk4("post_hold", 8'd3, 8'd16, 8'd0, 8'd0);

    // Reset while in S1, then restart
    rst = 1'b1;
    tick();
    chk4("rst_s1", 8'd0, 8'd0, 8'd0, 8'd0);
    rst = 1'b0;
    tick();
    chk4("restart", 8'd3, 8'd16, 8'd0, 8'd0);
    tick();
    tick();
    chk4("restart_end", 8'd9, 8'd48, 8'd57, 8'd39);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
